// File: rtl/sump_cmd_decoder_pkg.sv
// Shared definitions for the SUMP command decoder: opcode map, FSM states
// and the command word type.
package sump_cmd_decoder_pkg;

    typedef logic [31:0] cmd_word_t;

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    // Short commands (bit 7 clear)
    localparam logic [7:0] OP_RESET = 8'h00;
    localparam logic [7:0] OP_ARM   = 8'h01;
    localparam logic [7:0] OP_ID    = 8'h02;

    // Long commands (bit 7 set); stage opcodes carry the stage in bits 3:2
    localparam logic [7:0] OP_SET_MASK_BASE = 8'hC0;
    localparam logic [7:0] OP_SET_VAL_BASE  = 8'hC1;
    localparam logic [7:0] OP_SET_CFG_BASE  = 8'hC2;
    localparam logic [7:0] OP_SET_DIV       = 8'h80;
    localparam logic [7:0] OP_SET_CNT       = 8'h81;
    localparam logic [7:0] OP_SET_FLGS      = 8'h82;

    localparam logic [7:0] STAGE_FIELD_MASK = 8'h0C;

endpackage

// File: rtl/sump_cmd_decoder.sv
// Assembles SUMP short (1-byte) and long (opcode + 4 data bytes, LSB first)
// commands into a 32-bit word plus one-cycle strobes, with an inter-byte timeout.
module sump_cmd_decoder
    import sump_cmd_decoder_pkg::*;
#(
    parameter int STAGES  = 4,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_vld_i,
    output logic [31:0]       cmd_o,
    output logic [STAGES-1:0] set_mask_o,
    output logic [STAGES-1:0] set_val_o,
    output logic [STAGES-1:0] set_cfg_o,
    output logic              set_div_o,
    output logic              set_cnt_o,
    output logic              set_flgs_o,
    output logic              arm_o,
    output logic              sreset_o,
    output logic              id_o,
    output logic              busy_o
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  opcode;
    cmd_word_t   shadow;
    logic [1:0]  byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]  kind_op;

    assign kind_op = opcode & ~STAGE_FIELD_MASK;

    always_ff @(posedge clk_i) begin
        // NOTE: strobes default low every cycle so each branch only raises its own
        // pulse; later non-blocking writes in the same block override this default.
        set_mask_o <= '0;
        set_val_o  <= '0;
        set_cfg_o  <= '0;
        set_div_o  <= 1'b0;
        set_cnt_o  <= 1'b0;
        set_flgs_o <= 1'b0;
        arm_o      <= 1'b0;
        sreset_o   <= 1'b0;
        id_o       <= 1'b0;

        if (rst_i) begin
            state    <= IDLE;
            opcode   <= '0;
            shadow   <= '0;
            byte_cnt <= '0;
            tmo_cnt  <= '0;
            cmd_o    <= '0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_vld_i) begin
                        if (rx_data_i[7]) begin
                            opcode   <= rx_data_i;
                            byte_cnt <= '0;
                            tmo_cnt  <= '0;
                            busy_o   <= 1'b1;
                            state    <= DATA;
                        end else begin
                            case (rx_data_i)
                                OP_RESET: sreset_o <= 1'b1;
                                OP_ARM:   arm_o    <= 1'b1;
                                OP_ID:    id_o     <= 1'b1;
                                default:  ;
                            endcase
                        end
                    end
                end

                DATA: begin
                    if (rx_vld_i) begin
                        tmo_cnt <= '0;
                        shadow[{byte_cnt, 3'b000} +: 8] <= rx_data_i;
                        if (byte_cnt == 2'd3) begin
                            cmd_o  <= {rx_data_i, shadow[23:0]};
                            busy_o <= 1'b0;
                            state  <= IDLE;
                            // Stage strobes: stages beyond STAGES match no index and drop out
                            for (int i = 0; i < STAGES; i++) begin
                                if (opcode[3:2] == 2'(i)) begin
                                    case (kind_op)
                                        OP_SET_MASK_BASE: set_mask_o[i] <= 1'b1;
                                        OP_SET_VAL_BASE:  set_val_o[i]  <= 1'b1;
                                        OP_SET_CFG_BASE:  set_cfg_o[i]  <= 1'b1;
                                        default:          ;
                                    endcase
                                end
                            end
                            case (opcode)
                                OP_SET_DIV:  set_div_o  <= 1'b1;
                                OP_SET_CNT:  set_cnt_o  <= 1'b1;
                                OP_SET_FLGS: set_flgs_o <= 1'b1;
                                default:     ;
                            endcase
                        end else begin
                            byte_cnt <= byte_cnt + 2'd1;
                        end
                    end else if (TIMEOUT != 0 && tmo_cnt == TMO_LAST) begin
                        // Abort: the partial word is dropped and cmd_o keeps its old value
                        state    <= IDLE;
                        busy_o   <= 1'b0;
                        byte_cnt <= '0;
                        tmo_cnt  <= '0;
                        shadow   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sump_cmd_decoder.sv
// Directed bench for sump_cmd_decoder: a 4-stage and a 2-stage instance share
// one byte stream, both with a 16-cycle inter-byte timeout.
module tb_sump_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_vld;

    logic [31:0] cmd_a, cmd_b;
    logic [3:0]  mask_a, val_a, cfg_a;
    logic [1:0]  mask_b, val_b, cfg_b;
    logic        div_a, cnt_a, flgs_a, arm_a, sreset_a, id_a, busy_a;
    logic        div_b, cnt_b, flgs_b, arm_b, sreset_b, id_b, busy_b;

    logic [17:0] str_a;
    logic [11:0] str_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sump_cmd_decoder #(.STAGES(4), .TIMEOUT(16)) dut_a (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_vld_i(rx_vld),
        .cmd_o(cmd_a), .set_mask_o(mask_a), .set_val_o(val_a), .set_cfg_o(cfg_a),
        .set_div_o(div_a), .set_cnt_o(cnt_a), .set_flgs_o(flgs_a), .arm_o(arm_a),
        .sreset_o(sreset_a), .id_o(id_a), .busy_o(busy_a)
    );

    sump_cmd_decoder #(.STAGES(2), .TIMEOUT(16)) dut_b (
        .clk_i(clk), .rst_i(rst), .rx_data_i(rx_data), .rx_vld_i(rx_vld),
        .cmd_o(cmd_b), .set_mask_o(mask_b), .set_val_o(val_b), .set_cfg_o(cfg_b),
        .set_div_o(div_b), .set_cnt_o(cnt_b), .set_flgs_o(flgs_b), .arm_o(arm_b),
        .sreset_o(sreset_b), .id_o(id_b), .busy_o(busy_b)
    );

    // Strobe layout: {mask, val, cfg, div, cnt, flgs, arm, sreset, id}
    assign str_a = {mask_a, val_a, cfg_a, div_a, cnt_a, flgs_a, arm_a, sreset_a, id_a};
    assign str_b = {mask_b, val_b, cfg_b, div_b, cnt_b, flgs_b, arm_b, sreset_b, id_b};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the next negedge, where the registered
    // response to this byte is already visible.
    task automatic send(input logic [7:0] b);
        rx_data = b;
        rx_vld  = 1'b1;
        @(negedge clk);
        rx_vld  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [17:0] sticky_a;
    logic [11:0] sticky_b;
    int          sreset_seen;

    initial begin
        rst = 1'b1;
        rx_data = 8'h00;
        rx_vld = 1'b0;
        idle(3);
        check("reset_strobes_a", str_a, 0);
        check("reset_cmd_a", cmd_a, 0);
        check("reset_busy_a", busy_a, 0);
        check("reset_strobes_b", str_b, 0);
        rst = 1'b0;
        idle(1);

        // Short command: arm
        send(8'h01);
        check("arm_pulse", str_a, {4'b0, 4'b0, 4'b0, 6'b000100});
        check("arm_busy", busy_a, 0);
        idle(1);
        check("arm_one_cycle", str_a, 0);

        // Ignored short code
        send(8'h13);
        check("short_ignored", str_a, 0);

        // Set mask stage 1 with 0x12345678
        send(8'hC4);
        check("c4_busy_after_op", busy_a, 1);
        send(8'h78);
        send(8'h56);
        send(8'h34);
        check("c4_busy_mid", busy_a, 1);
        check("c4_no_early_cmd", cmd_a, 0);
        send(8'h12);
        check("c4_mask_a", str_a, {4'b0010, 4'b0, 4'b0, 6'b0});
        check("c4_cmd_a", cmd_a, 32'h12345678);
        check("c4_busy_drop", busy_a, 0);
        check("c4_mask_b", str_b, {2'b10, 2'b0, 2'b0, 6'b0});
        idle(1);
        check("c4_one_cycle", str_a, 0);

        // Set config stage 0, then ID byte in the strobe cycle
        send(8'hC2);
        send(8'hEF);
        send(8'hBE);
        send(8'hAD);
        send(8'hDE);
        check("c2_cfg_a", str_a, {4'b0, 4'b0, 4'b0001, 6'b0});
        check("c2_cmd_a", cmd_a, 32'hDEADBEEF);
        send(8'h02);
        check("id_back_to_back", str_a, {4'b0, 4'b0, 4'b0, 6'b000001});
        check("id_b", str_b, {2'b0, 2'b0, 2'b0, 6'b000001});

        // Timeout: partial set_cnt aborted after 16 idle cycles
        sticky_a = '0;
        send(8'h81);
        send(8'hAA);
        send(8'hBB);
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            sticky_a = sticky_a | str_a;
        end
        check("tmo_busy_at_15", busy_a, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sticky_a = sticky_a | str_a;
            if (i == 0) check("tmo_busy_at_16", busy_a, 0);
        end
        check("tmo_no_strobe", sticky_a, 0);
        check("tmo_cmd_kept", cmd_a, 32'hDEADBEEF);
        send(8'h01);
        check("tmo_then_arm", str_a, {4'b0, 4'b0, 4'b0, 6'b000100});

        // Unknown long opcode
        send(8'h9E);
        send(8'h01);
        send(8'h02);
        send(8'h03);
        send(8'h04);
        check("9e_no_strobe", str_a, 0);
        check("9e_cmd", cmd_a, 32'h04030201);
        check("9e_busy", busy_a, 0);

        // Stage 3 mask: present on the 4-stage instance only
        send(8'hCC);
        send(8'h11);
        send(8'h22);
        send(8'h33);
        send(8'h44);
        check("cc_mask_a", str_a, {4'b1000, 4'b0, 4'b0, 6'b0});
        check("cc_none_b", str_b, 0);
        check("cc_cmd_b", cmd_b, 32'h44332211);

        // Reset in the middle of a set_val command
        send(8'hC1);
        send(8'hAA);
        send(8'hBB);
        rst = 1'b1;
        rx_data = 8'hCC;
        rx_vld = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rx_vld = 1'b0;
        check("rst_mid_strobes", str_a, 0);
        check("rst_mid_cmd", cmd_a, 0);
        check("rst_mid_busy", busy_a, 0);
        idle(1);
        check("rst_mid_after", str_a, 0);
        send(8'hC5);
        send(8'h0D);
        send(8'hF0);
        send(8'hAD);
        send(8'h0B);
        check("post_rst_val", str_a, {4'b0, 4'b0010, 4'b0, 6'b0});
        check("post_rst_cmd", cmd_a, 32'h0BADF00D);

        // Resync: five zeros from inside a long command
        sreset_seen = 0;
        sticky_b = '0;
        send(8'hC0);
        send(8'h55);
        for (int i = 0; i < 5; i++) begin
            send(8'h00);
            if (sreset_a) sreset_seen++;
            sticky_b = sticky_b | str_b;
        end
        idle(1);
        check("resync_busy", busy_a, 0);
        check("resync_sreset_seen", sreset_seen > 0, 1);
        check("resync_b_strobes", sticky_b, {2'b01, 2'b0, 2'b0, 6'b000010});
        check("resync_cmd", cmd_a, 32'h00000055);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
